// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler with a one-entry output register.
// A frame begins on a bit flagged frame_start. Its dir value picks MSB-first
// or LSB-first order for the whole frame. After WIDTH accepted bits, the word
// moves to the output register, or it is dropped and overflow is flagged when
// the previous word has not been consumed.
module serial_word_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             frame_start,
   input  logic             dir,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic             overflow,
   output logic             framing_err,
   input  logic             err_clr
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             dir_reg, dir_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [WIDTH-1:0] word_reg, word_next;
   logic             valid_reg, valid_next;
   logic             ovf_reg, ovf_next;
   logic             ferr_reg, ferr_next;

   logic             restart, take_bit, ferr_set, complete, load;
   logic             shift_dir;
   logic [WIDTH-1:0] shift_base, shift_msb, shift_lsb, acc_shift;

   // A frame_start bit always restarts, and counts as bit 1. Only a plain bit
   // arriving in SHIFT can be the last one, so a restart never completes a word.
   assign restart   = bit_valid && frame_start;
   assign take_bit  = bit_valid && !frame_start && (state_reg == SHIFT);
   assign ferr_set  = restart && (state_reg == SHIFT);
   assign complete  = take_bit && (cnt_reg == CW'(WIDTH - 1));
   assign load      = complete && (!valid_reg || word_ready);

   // A restart shifts into a cleared accumulator and uses the live dir input.
   assign shift_base = restart ? '0 : acc_reg;
   assign shift_dir  = restart ? dir : dir_reg;

   // Shift datapath, built one bit at a time.
   // MSB-first: shift toward the MSB and insert the new bit at bit 0.
   // LSB-first: shift toward the LSB and insert the new bit at bit WIDTH-1.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lo
         assign shift_msb[gi] = bit_in;
      end else begin : g_lo
         assign shift_msb[gi] = shift_base[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_hi
         assign shift_lsb[gi] = bit_in;
      end else begin : g_hi
         assign shift_lsb[gi] = shift_base[gi+1];
      end
   end

   assign acc_shift = shift_dir ? shift_lsb : shift_msb;

   // Next-state logic: frame sequencing, output register handoff and sticky flags.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dir_next   = dir_reg;
      acc_next   = acc_reg;
      word_next  = word_reg;
      valid_next = valid_reg;

      if (restart) begin
         state_next = SHIFT;
         cnt_next   = CW'(1);
         dir_next   = dir;
         acc_next   = acc_shift;
      end else if (take_bit) begin
         acc_next = acc_shift;
         if (complete) begin
            state_next = IDLE;
            cnt_next   = '0;
         end else begin
            cnt_next = cnt_reg + CW'(1);
         end
      end

      // A reload in the same cycle as a transfer keeps word_valid high.
      if (load) begin
         word_next  = acc_shift;
         valid_next = 1'b1;
      end else if (valid_reg && word_ready) begin
         valid_next = 1'b0;
      end

      // Setting a flag takes priority over err_clr in the same cycle.
      ovf_next  = (complete && !load) || (ovf_reg && !err_clr);
      ferr_next = ferr_set || (ferr_reg && !err_clr);
   end

   // State register. Reset discards any partial frame and any pending word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         dir_reg   <= 1'b0;
         acc_reg   <= '0;
         word_reg  <= '0;
         valid_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         ferr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         dir_reg   <= dir_next;
         acc_reg   <= acc_next;
         word_reg  <= word_next;
         valid_reg <= valid_next;
         ovf_reg   <= ovf_next;
         ferr_reg  <= ferr_next;
      end
   end

   assign word_out    = word_reg;
   assign word_valid  = valid_reg;
   assign busy        = (state_reg == SHIFT);
   assign overflow    = ovf_reg;
   assign framing_err = ferr_reg;

endmodule

// File: doc/serial_word_deserializer.md
SERIAL_WORD_DESERIALIZER -- requirements
Module: serial_word_deserializer

Interface
REQ-001 Parameter SHALL be: WIDTH, 8, word length in bits (legal range 2..32).
REQ-002 Port SHALL be: clk  input  1  sole clock, all state updates on posedge.
REQ-003 Port SHALL be: rst  input  1  reset, synchronous, active-high.
REQ-004 Port SHALL be: bit_valid  input  1  bit_in carries a bit this cycle.
REQ-005 Port SHALL be: bit_in  input  1  serial data bit.
REQ-006 Port SHALL be: frame_start  input  1  qualified by bit_valid; marks the first bit of a word.
REQ-007 Port SHALL be: dir  input  1  sampled with the frame_start bit; 0 = MSB-first, 1 = LSB-first.
REQ-008 Port SHALL be: word_out  output  WIDTH  assembled word.
REQ-009 Port SHALL be: word_valid  output  1  word_out holds an unconsumed word.
REQ-010 Port SHALL be: word_ready  input  1  consumer accepts word_out when word_valid is high.
REQ-011 Port SHALL be: busy  output  1  frame in progress (state SHIFT).
REQ-012 Port SHALL be: overflow  output  1  sticky; completed word dropped.
REQ-013 Port SHALL be: framing_err  output  1  sticky; frame restarted before completion.
REQ-014 Port SHALL be: err_clr  input  1  clears both sticky flags.

Function
REQ-015 States SHALL be IDLE and SHIFT; a bit counter (clog2(WIDTH+1) bits), dir_lat register, accumulator, and one-entry output register SHALL be kept.
REQ-016 In IDLE: bit_valid && frame_start -> accept bit as bit 1, latch dir into dir_lat, counter=1, go SHIFT; bit_valid without frame_start -> ignore bit.
REQ-017 Accepting a bit SHALL update the accumulator: dir_lat=0 -> {acc[WIDTH-2:0], bit_in}; dir_lat=1 -> {bit_in, acc[WIDTH-1:1]}.
REQ-018 In SHIFT: bit_valid && !frame_start -> accept bit, counter+1; cycles without bit_valid -> hold all state (no timeout).
REQ-019 In SHIFT: bit_valid && frame_start -> discard partial word, set framing_err, restart as in REQ-016 in the same cycle.
REQ-020 When the WIDTH-th bit is accepted, the complete word SHALL move to the output register on that clock edge, state -> IDLE, counter -> 0; word_valid rises the next cycle (latency 1 cycle after last bit).
REQ-021 Completion SHALL load the output register if word_valid is 0 or word_ready is 1 in that cycle; otherwise the new word is dropped, overflow is set, and word_out/word_valid are unchanged.
REQ-022 word_valid && word_ready SHALL be a transfer; word_valid falls next cycle unless a completion reloads it in the same cycle.
REQ-023 While word_valid && !word_ready, word_out SHALL stay stable.
REQ-024 busy SHALL be 1 exactly while in SHIFT.
REQ-025 err_clr SHALL clear overflow and framing_err; a set event in the same cycle SHALL win (flag stays 1).
REQ-026 A frame_start bit that both restarts and (WIDTH unaffected) counts as bit 1 SHALL never complete a word in that same cycle.

Reset
REQ-027 rst=1 at a clock edge SHALL force: state IDLE, counter 0, accumulator 0, word_out 0, word_valid 0, busy 0, overflow 0, framing_err 0.
REQ-028 Reset SHALL take priority over all inputs, including mid-frame and with word_valid pending; partial and pending words are lost.

Verification
REQ-029 WIDTH=8, dir=0, bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles, word_ready=1 -> word_out=0xB2, word_valid high 1 cycle after bit 8, then low.
REQ-030 WIDTH=8, dir=1, same bit sequence -> word_out=0x4D; bit_valid gaps of 3 cycles inserted mid-frame -> same result.
REQ-031 word_ready=0, two full frames 0xB2 then 0x11 -> word_out stays 0xB2, overflow=1; err_clr pulse -> overflow=0.
REQ-032 Completion of 0x11 in same cycle as word_ready=1 for pending 0xB2 -> 0xB2 transferred, word_out=0x11 valid next cycle, overflow=0.
REQ-033 frame_start after 5 bits, then 8 bits (first with frame_start) of 0x3C -> framing_err=1, word_out=0x3C.
REQ-034 rst asserted after 4 bits with a word pending -> all outputs 0 next cycle; following frame 0xA5 decodes correctly.
